// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg
//   Shared widths and defaults for the register-file write-back arbiter.
//   REG_ADDR_W / REG_DATA_W : register address / data widths
//   REG_NUM                 : number of architectural registers
//   WB_REQ_NUM              : default number of write-back requesters
//   WB_ID_W                 : width of a requester index
//   ZERO_WORD               : reset value of a data word
package wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_NUM    = 32;
  localparam int WB_REQ_NUM = 3;
  localparam int WB_ID_W    = $clog2(WB_REQ_NUM);

  localparam logic [REG_DATA_W-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// rr_pick
//   Purely combinational round-robin picker.
//   i_valid : request vector
//   i_start : index with highest priority this cycle (0..NREQ-1)
//   o_grant : one-hot grant (all zero when nothing is valid)
//   o_idx   : index of the granted requester (0 when nothing is valid)
//   o_any   : at least one requester is valid
module rr_pick
  import wb_arbiter_pkg::*;
#(
  parameter int NREQ = WB_REQ_NUM,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [ID_W-1:0] i_start,
  output logic [NREQ-1:0] o_grant,
  output logic [ID_W-1:0] o_idx,
  output logic            o_any
);

  // One extra bit so start+offset can exceed NREQ before the wrap.
  localparam logic [ID_W:0] NREQ_W = (ID_W+1)'(NREQ);

  logic [ID_W:0]   w_pos;
  logic [ID_W-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_pos   = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      // Modulo by subtraction: NREQ need not be a power of two.
      w_pos = {1'b0, i_start} + (ID_W+1)'(k);
      if (w_pos >= NREQ_W) begin
        w_pos = w_pos - NREQ_W;
      end
      w_idx = w_pos[ID_W-1:0];
      if (!o_any && i_valid[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_idx          = w_idx;
        o_any          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter
//   Shares the register file's single write port among NREQ write-back
//   sources with a round-robin valid/ready handshake. The winning write is
//   registered one cycle and driven onto rf_we/rf_waddr/rf_wdata. Writes to
//   x0 are consumed but never raise rf_we.
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_req_valid      : per-requester write request
//   o_req_ready      : per-requester grant (transfer = valid & ready)
//   i_req_addr/data  : packed per-requester address/data, requester i at [i*W +: W]
//   o_rf_we/waddr/wdata : registered register-file write port
//   o_grant_id       : requester whose write is currently on o_rf_*
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int  NREQ   = WB_REQ_NUM,
  parameter int  ADDR_W = REG_ADDR_W,
  parameter int  DATA_W = REG_DATA_W,
  localparam int ID_W   = $clog2(NREQ)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NREQ-1:0]          i_req_valid,
  output logic [NREQ-1:0]          o_req_ready,
  input  logic [NREQ*ADDR_W-1:0]   i_req_addr,
  input  logic [NREQ*DATA_W-1:0]   i_req_data,
  output logic                     o_rf_we,
  output logic [ADDR_W-1:0]        o_rf_waddr,
  output logic [DATA_W-1:0]        o_rf_wdata,
  output logic [ID_W-1:0]          o_grant_id
);

  logic [ID_W-1:0]   r_rr_ptr;
  logic              r_rf_we;
  logic [ADDR_W-1:0] r_rf_waddr;
  logic [DATA_W-1:0] r_rf_wdata;
  logic [ID_W-1:0]   r_grant_id;

  logic [NREQ-1:0]   w_grant;
  logic [ID_W-1:0]   w_gidx;
  logic              w_any;
  logic              w_last;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;

  rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_rr_pick (
    .i_valid (i_req_valid),
    .i_start (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_any   (w_any)
  );

  // Nothing may be handed off while reset is held; pending requests are
  // simply not acknowledged and get reissued after release.
  assign o_req_ready = i_rst_n ? w_grant : '0;

  assign w_last = (w_gidx == ID_W'(NREQ-1));
  assign w_addr = i_req_addr[w_gidx*ADDR_W +: ADDR_W];
  assign w_data = i_req_data[w_gidx*DATA_W +: DATA_W];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr_ptr   <= '0;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= ZERO_WORD[DATA_W-1:0];
      r_grant_id <= '0;
    end else if (w_any) begin
      r_rr_ptr   <= w_last ? '0 : w_gidx + 1'b1;
      // x0 is granted and consumed but never written.
      r_rf_we    <= (w_addr != '0);
      r_rf_waddr <= w_addr;
      r_rf_wdata <= w_data;
      r_grant_id <= w_gidx;
    end else begin
      r_rf_we    <= 1'b0;
    end
  end

  assign o_rf_we    = r_rf_we;
  assign o_rf_waddr = r_rf_waddr;
  assign o_rf_wdata = r_rf_wdata;
  assign o_grant_id = r_grant_id;

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Shares the register file's single write port among NREQ write-back sources, such as the ALU, load unit and multi-cycle mul/div. It uses a round-robin valid/ready handshake to pick one source per cycle. The winning write is registered one cycle and driven onto the register file's we/waddr/wdata inputs. Writes to x0 are accepted and consumed but never asserted on the write port.

Parameters:
NREQ, 3, number of write-back requesters (2..8, need not be a power of two)
ADDR_W, 5, register address width (matches `RegAddrBus)
DATA_W, 32, register data width (matches `RegBus)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous reset, active-low (0 = in reset)
req_valid  input  NREQ  per-requester write request valid
req_ready  output  NREQ  per-requester grant; transfer = valid & ready
req_addr  input  NREQ*ADDR_W  packed destination register addresses; requester i at bits [i*ADDR_W +: ADDR_W]
req_data  input  NREQ*DATA_W  packed write data; requester i at bits [i*DATA_W +: DATA_W]
rf_we  output  1  register file write enable (registered)
rf_waddr  output  ADDR_W  register file write address (registered)
rf_wdata  output  DATA_W  register file write data (registered)
grant_id  output  clog2(NREQ)  index of requester whose write is currently on rf_* (registered)

Behaviour:
- State: rr_ptr (clog2(NREQ) bits) plus the output register (rf_we, rf_waddr, rf_wdata, grant_id).
- Reset (rst=0, asynchronous):
  - rr_ptr=0, rf_we=0, rf_waddr=0, rf_wdata=`ZeroWord, grant_id=0.
  - req_ready forced to all-zero combinationally while rst=0.
- Arbitration (combinational):
  - Scan requesters starting at rr_ptr, ascending index, wrapping modulo NREQ.
  - The first requester with req_valid=1 is g; req_ready[g]=1 and all other bits are 0.
  - No valid requester gives req_ready=0.
  - req_ready may depend on req_valid; req_valid must not depend on req_ready.
- Pointer update:
  - On a transfer, rr_ptr <= (g==NREQ-1) ? 0 : g+1.
  - With no transfer, rr_ptr holds.
- Output stage, latency exactly 1 cycle from transfer edge to rf_* valid:
  - On transfer: rf_we <= (req_addr[g]!=0), rf_waddr <= req_addr[g], rf_wdata <= req_data[g], grant_id <= g.
  - No transfer: rf_we <= 0; rf_waddr, rf_wdata and grant_id hold their previous values.
- x0: an address-0 request is granted normally (ready=1, pointer advances) but produces rf_we=0.
- Throughput: one write per cycle, sustained. A single continuous requester is granted every cycle.
- Same destination from two requesters in the same cycle: only the granted one transfers. The other remains pending and writes in a later cycle, so the later grant wins in the register file.
- Requesters hold addr/data stable while valid=1 and ready=0. The arbiter neither samples nor checks them otherwise.
- Reset asserted mid-stream:
  - The registered write is dropped immediately (rf_we=0 without waiting for clk).
  - Un-granted requests are not retained; requesters reissue after reset release.
- The first grant is possible in the first clk edge after rst deasserts.

Decomposition:
- Shared defines file: `RegAddrBus, `RegBus, `ZeroWord, `RegNum. Add `WbReqNum for NREQ and `WbIdBus for the grant_id width.
- One sub-module, rr_pick: purely combinational. Inputs are the valid vector and start pointer; outputs are the one-hot grant, the grant index and an any-valid flag.
- wb_arbiter instantiates rr_pick and holds rr_ptr and the output register.

Test Plan:
1. Hold rst=0 with req_valid=3'b111 → req_ready=000, rf_we=0, rf_waddr=0, rf_wdata=0. Release rst; after the first edge, rf_we=1 and grant_id=0.
2. Only requester 1 valid, addr=5, data=32'hDEADBEEF, held 4 cycles → req_ready=3'b010 every cycle. From the next cycle, rf_we=1, rf_waddr=5, rf_wdata=32'hDEADBEEF for 4 consecutive cycles, then rf_we=0.
3. All three valid continuously with addrs 1/2/3 and data 11/22/33 from reset → grants 0,1,2,0,1 on successive edges. rf_waddr sequence is 1,2,3,1,2, each delayed one cycle.
4. Requester 2 valid, addr=0, data=32'h1234 → req_ready[2]=1; the next cycle rf_we=0 and grant_id=2. rr_ptr wraps to 0, so requester 0 then beats requester 1 when both are valid.
5. rr_ptr=2 (after granting 1), only requesters 0 and 1 valid → grant 0 (wrap). Next cycle grant 1.
6. During stream 3, drive rst low mid-cycle (not on an edge) → rf_we and req_ready drop immediately. After release, grants restart at requester 0.
